// File: rtl/branch_resolve.sv
// Branch resolution pipeline: carries the D-stage prediction through E and M,
// resolves the real direction in E, and in M issues the predictor update strobe,
// the misprediction redirect and the branch/mispredict statistics.
module branch_resolve #(
    parameter int unsigned FALL_OFFSET = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             stallM,
    input  logic             flushE,
    input  logic             flushM,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [31:0]      pcD,
    input  logic [31:0]      targetD,
    input  logic [2:0]       br_typeD,
    input  logic [31:0]      srcaE,
    input  logic [31:0]      srcbE,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [31:0]      pcM,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam logic [31:0] FALL_INC = FALL_OFFSET[31:0];

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BGEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLEZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;

    // E-stage register
    logic        validE;
    logic        pred_takeE;
    logic [31:0] pcE;
    logic [31:0] targetE;
    logic [2:0]  br_typeE;

    // M-stage register
    logic        validM;
    logic        takeM;
    logic [31:0] pcM_r;
    logic        mispM;
    logic [31:0] correct_pcM;

    logic        condE;
    logic        actual_takeE;
    logic        mispE;
    logic [31:0] correct_pcE;
    logic        fireM;

    // D->E register: flush wins over stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validE     <= 1'b0;
            pred_takeE <= 1'b0;
            pcE        <= 32'd0;
            targetE    <= 32'd0;
            br_typeE   <= 3'd0;
        end else if (flushE) begin
            validE <= 1'b0;
        end else if (!stallE) begin
            validE     <= branchD;
            pred_takeE <= pred_takeD;
            pcE        <= pcD;
            targetE    <= targetD;
            br_typeE   <= br_typeD;
        end
    end

    // E-stage signed condition evaluation and corrected PC
    always_comb begin
        condE = 1'b0;
        case (br_typeE)
            BR_BEQ:  condE = (srcaE == srcbE);
            BR_BNE:  condE = (srcaE != srcbE);
            BR_BGEZ: condE = ($signed(srcaE) >= 32'sd0);
            BR_BGTZ: condE = ($signed(srcaE) >  32'sd0);
            BR_BLEZ: condE = ($signed(srcaE) <= 32'sd0);
            BR_BLTZ: condE = ($signed(srcaE) <  32'sd0);
            default: condE = 1'b0;
        endcase
        actual_takeE = validE & condE;
        mispE        = validE & (pred_takeE != actual_takeE);
        correct_pcE  = actual_takeE ? targetE : (pcE + FALL_INC);
    end

    // E->M register: an E stall with M free inserts a bubble into M
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validM      <= 1'b0;
            takeM       <= 1'b0;
            pcM_r       <= 32'd0;
            mispM       <= 1'b0;
            correct_pcM <= 32'd0;
        end else if (flushM) begin
            validM <= 1'b0;
        end else if (stallM) begin
            validM <= validM;
        end else if (stallE) begin
            validM <= 1'b0;
        end else begin
            validM      <= validE;
            takeM       <= actual_takeE;
            pcM_r       <= pcE;
            mispM       <= mispE;
            correct_pcM <= correct_pcE;
        end
    end

    // M-stage outputs; fire only on the cycle the branch leaves M
    always_comb begin
        fireM        = validM & ~stallM & ~flushM;
        branchM      = fireM;
        actual_takeM = validM & takeM;
        pcM          = validM ? pcM_r : 32'd0;
        redirect     = fireM & mispM;
        redirect_pc  = redirect ? correct_pcM : 32'd0;
    end

    // Statistics counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (fireM) begin
            br_cnt <= br_cnt + 1'b1;
            if (mispM) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule
